// File: rtl/dac_wave_sequencer_pkg.sv
// ============================================================================
// wave_pkg : shared types and constants for the DAC waveform sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package wave_pkg;

    localparam int ROM_AW = 12;
    localparam int DAC_W  = 8;

    localparam logic [1:0] WAVE_SQ  = 2'd0;
    localparam logic [1:0] WAVE_SIN = 2'd1;
    localparam logic [1:0] WAVE_TRI = 2'd2;
    localparam logic [1:0] WAVE_OFF = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_FETCH  = 3'd2,
        ST_SCALE  = 3'd3,
        ST_SETUP  = 3'd4,
        ST_STROBE = 3'd5,
        ST_HOLD   = 3'd6
    } seq_state_e;

    // Full scale passes the sample through untouched; otherwise amp/16.
    function automatic logic [DAC_W-1:0] scale_sample(input logic [DAC_W-1:0] data,
                                                      input logic [3:0]       amp);
        logic [11:0] prod;
        prod = {4'b0000, data} * {8'h00, amp};
        if (amp == 4'd15) begin
            return data;
        end
        return DAC_W'(prod >> 4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_wave_sequencer_sample_tick_gen.sv
// ============================================================================
// sample_tick_gen : one-cycle tick every SAMPLE_DIV clocks while enabled
// Revision : 1.0
// ============================================================================
`default_nettype none

module sample_tick_gen #(
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/dac_wave_sequencer.sv
// ============================================================================
// dac_wave_sequencer : phase-accumulated ROM fetch, scaling and DAC write strobe
// Revision : 1.0
// ============================================================================
`default_nettype none

module dac_wave_sequencer
    import wave_pkg::*;
#(
    parameter int SAMPLE_DIV = 100,
    parameter int WR_LOW     = 2,
    parameter int PHASE_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        freq_word,
    input  logic [1:0]        wave_sel,
    input  logic [3:0]        amp,
    input  logic              ch_sel,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DAC_W-1:0]  rom_sq,
    input  logic [DAC_W-1:0]  rom_sin,
    input  logic [DAC_W-1:0]  rom_tri,
    output logic              dac_cs,
    output logic              dac_wr,
    output logic              dac_ab,
    output logic [DAC_W-1:0]  dac_data,
    output logic              busy,
    output logic              overrun
);

    localparam int             WCW     = (WR_LOW > 1) ? $clog2(WR_LOW) : 1;
    localparam logic [WCW-1:0] WR_LAST = WCW'(WR_LOW - 1);

    logic tick;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (enable),
        .clr  (!enable),
        .tick (tick)
    );

    seq_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic [1:0]         wave_q, wave_d;
    logic [3:0]         amp_q, amp_d;
    logic               ch_q, ch_d;
    logic [DAC_W-1:0]   sel_q, sel_d;
    logic [WCW-1:0]     wr_cnt_q, wr_cnt_d;
    logic               dac_cs_q, dac_cs_d;
    logic               dac_wr_q, dac_wr_d;
    logic               dac_ab_q, dac_ab_d;
    logic [DAC_W-1:0]   dac_data_q, dac_data_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rom_addr_d = rom_addr_q;
        wave_d     = wave_q;
        amp_d      = amp_q;
        ch_d       = ch_q;
        sel_d      = sel_q;
        wr_cnt_d   = wr_cnt_q;
        dac_cs_d   = dac_cs_q;
        dac_wr_d   = dac_wr_q;
        dac_ab_d   = dac_ab_q;
        dac_data_d = dac_data_q;
        // A tick that lands mid-sequence is dropped and only flagged.
        overrun_d  = overrun_q | (tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    wave_d     = wave_sel;
                    amp_d      = amp;
                    ch_d       = ch_sel;
                    rom_addr_d = phase_q[PHASE_W-1 -: ROM_AW];
                    phase_d    = phase_q + PHASE_W'(freq_word);
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                case (wave_q)
                    WAVE_SQ:  sel_d = rom_sq;
                    WAVE_SIN: sel_d = rom_sin;
                    WAVE_TRI: sel_d = rom_tri;
                    default:  sel_d = '0;
                endcase
                state_d = ST_SCALE;
            end
            ST_SCALE: begin
                dac_data_d = scale_sample(sel_q, amp_q);
                dac_ab_d   = ch_q;
                dac_cs_d   = 1'b0;
                state_d    = ST_SETUP;
            end
            ST_SETUP: begin
                dac_wr_d = 1'b0;
                wr_cnt_d = '0;
                state_d  = ST_STROBE;
            end
            ST_STROBE: begin
                if (wr_cnt_q == WR_LAST) begin
                    dac_wr_d = 1'b1;
                    state_d  = ST_HOLD;
                end else begin
                    wr_cnt_d = wr_cnt_q + WCW'(1);
                end
            end
            ST_HOLD: begin
                dac_cs_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!enable) begin
            phase_d = '0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            rom_addr_q <= '0;
            wave_q     <= WAVE_SQ;
            amp_q      <= '0;
            ch_q       <= 1'b0;
            sel_q      <= '0;
            wr_cnt_q   <= '0;
            dac_cs_q   <= 1'b1;
            dac_wr_q   <= 1'b1;
            dac_ab_q   <= 1'b0;
            dac_data_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rom_addr_q <= rom_addr_d;
            wave_q     <= wave_d;
            amp_q      <= amp_d;
            ch_q       <= ch_d;
            sel_q      <= sel_d;
            wr_cnt_q   <= wr_cnt_d;
            dac_cs_q   <= dac_cs_d;
            dac_wr_q   <= dac_wr_d;
            dac_ab_q   <= dac_ab_d;
            dac_data_q <= dac_data_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign dac_cs   = dac_cs_q;
    assign dac_wr   = dac_wr_q;
    assign dac_ab   = dac_ab_q;
    assign dac_data = dac_data_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_wave_sequencer.sv
// ============================================================================
// tb_dac_wave_sequencer : directed vector bench for dac_wave_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dac_wave_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, ch_sel;
    logic [7:0]  freq_word;
    logic [1:0]  wave_sel;
    logic [3:0]  amp;
    logic [11:0] rom_addr;
    logic [7:0]  rom_sq, rom_sin, rom_tri;
    logic        dac_cs, dac_wr, dac_ab, busy, overrun;
    logic [7:0]  dac_data;

    logic        enable2;
    logic [11:0] rom_addr2;
    logic        cs2, wr2, ab2, busy2, overrun2;
    logic [7:0]  data2;

    int checks = 0;
    int errors = 0;

    dac_wave_sequencer u_dut (
        .clk(clk), .rst(rst), .enable(enable), .freq_word(freq_word),
        .wave_sel(wave_sel), .amp(amp), .ch_sel(ch_sel), .rom_addr(rom_addr),
        .rom_sq(rom_sq), .rom_sin(rom_sin), .rom_tri(rom_tri),
        .dac_cs(dac_cs), .dac_wr(dac_wr), .dac_ab(dac_ab), .dac_data(dac_data),
        .busy(busy), .overrun(overrun)
    );

    // Divider deliberately shorter than the write sequence.
    dac_wave_sequencer #(.SAMPLE_DIV(5)) u_fast (
        .clk(clk), .rst(rst), .enable(enable2), .freq_word(8'h10),
        .wave_sel(2'd0), .amp(4'd15), .ch_sel(1'b1), .rom_addr(rom_addr2),
        .rom_sq(8'hA5), .rom_sin(8'h00), .rom_tri(8'h00),
        .dac_cs(cs2), .dac_wr(wr2), .dac_ab(ab2), .dac_data(data2),
        .busy(busy2), .overrun(overrun2)
    );

    function automatic logic [7:0] sin_f(input logic [11:0] a);
        return a[7:0] + 8'h30;
    endfunction

    function automatic logic [7:0] tri_f(input logic [11:0] a);
        return ~a[7:0];
    endfunction

    // ROM model with one cycle of read latency
    always @(posedge clk) begin
        rom_sq  <= 8'hFF;
        rom_sin <= sin_f(rom_addr);
        rom_tri <= tri_f(rom_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (at negedges) for a chip-select window and measures it.
    task automatic wait_write(input bit which, input int budget,
                              output logic [7:0] d, output logic ab, output logic [11:0] a,
                              output int wr_low, output int cs_low, output bit ok);
        int  n;
        bit  first;
        logic last_wr;
        n = 0; wr_low = 0; cs_low = 0; ok = 1'b0; first = 1'b1; last_wr = 1'b1;
        d = '0; ab = 1'b0; a = '0;
        while ((which ? cs2 : dac_cs) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (which ? cs2 : dac_cs) return;
        d  = which ? data2 : dac_data;
        ab = which ? ab2 : dac_ab;
        a  = which ? rom_addr2 : rom_addr;
        ok = 1'b1;
        while (!(which ? cs2 : dac_cs) && cs_low < 20) begin
            cs_low++;
            last_wr = which ? wr2 : dac_wr;
            if (!last_wr) wr_low++;
            if (first && !last_wr) ok = 1'b0;
            if ((which ? data2 : dac_data) !== d) ok = 1'b0;
            first = 1'b0;
            @(negedge clk);
        end
        if (!last_wr || !(which ? cs2 : dac_cs)) ok = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  fw;
        logic [1:0]  ws;
        logic [3:0]  am;
        logic        ch;
        logic [11:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        logic        ab;
        logic [11:0] a;
        logic [15:0] phase_m;
        int          wl, cl, n;
        bit          ok;

        vecs[0]  = '{8'h10, 2'd1, 4'd15, 1'b0, 12'h000, 8'h30};
        vecs[1]  = '{8'h10, 2'd1, 4'd15, 1'b1, 12'h001, 8'h31};
        vecs[2]  = '{8'h10, 2'd1, 4'd15, 1'b0, 12'h002, 8'h32};
        vecs[3]  = '{8'h10, 2'd0, 4'd8,  1'b1, 12'h003, 8'h7F};
        vecs[4]  = '{8'h10, 2'd0, 4'd0,  1'b0, 12'h004, 8'h00};
        vecs[5]  = '{8'h10, 2'd3, 4'd15, 1'b1, 12'h005, 8'h00};
        vecs[6]  = '{8'h00, 2'd2, 4'd15, 1'b0, 12'h006, 8'hF9};
        vecs[7]  = '{8'h00, 2'd2, 4'd4,  1'b1, 12'h006, 8'h3E};
        vecs[8]  = '{8'hFF, 2'd1, 4'd15, 1'b0, 12'h006, 8'h36};
        vecs[9]  = '{8'hFF, 2'd1, 4'd3,  1'b1, 12'h015, 8'h0C};
        vecs[10] = '{8'h10, 2'd2, 4'd1,  1'b0, 12'h025, 8'h0D};
        vecs[11] = '{8'h10, 2'd0, 4'd14, 1'b1, 12'h026, 8'hDF};

        rst = 1'b1; enable = 1'b0; enable2 = 1'b0;
        freq_word = 8'h10; wave_sel = 2'd1; amp = 4'd15; ch_sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset dac_cs",   dac_cs,   1);
        chk("reset dac_wr",   dac_wr,   1);
        chk("reset dac_ab",   dac_ab,   0);
        chk("reset dac_data", dac_data, 0);
        chk("reset busy",     busy,     0);
        chk("reset overrun",  overrun,  0);
        chk("reset rom_addr", rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Overrun with a 5-cycle divider
        enable2 = 1'b1;
        n = 0;
        while (cs2 && n < 50) begin @(negedge clk); n++; end
        chk("fast first write seen", cs2, 0);
        chk("fast overrun before collision", overrun2, 0);
        for (int k = 0; k < 3; k++) begin
            wait_write(1'b1, 50, d, ab, a, wl, cl, ok);
            chk("fast write form", ok, 1);
            chk("fast data", d, 8'hA5);
            chk("fast ab", ab, 1);
            chk("fast wr low", wl, 2);
            chk("fast cs low", cl, 4);
            chk("fast overrun sticky", overrun2, 1);
        end
        enable2 = 1'b0;

        // Table-driven samples
        for (int i = 0; i < 12; i++) begin
            freq_word = vecs[i].fw; wave_sel = vecs[i].ws;
            amp = vecs[i].am; ch_sel = vecs[i].ch;
            enable = 1'b1;
            wait_write(1'b0, 250, d, ab, a, wl, cl, ok);
            chk($sformatf("vec%0d form", i), ok, 1);
            chk($sformatf("vec%0d addr", i), a, vecs[i].exp_addr);
            chk($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d ab", i), ab, vecs[i].ch);
            chk($sformatf("vec%0d wr low", i), wl, 2);
        end
        chk("no overrun at nominal rate", overrun, 0);

        // Phase wrap with the largest increment
        phase_m = 16'h027E;
        freq_word = 8'hFF; wave_sel = 2'd1; amp = 4'd15; ch_sel = 1'b0;
        for (int s = 0; s < 300; s++) begin
            wait_write(1'b0, 250, d, ab, a, wl, cl, ok);
            chk("wrap form", ok, 1);
            chk("wrap addr", a, phase_m[15:4]);
            chk("wrap data", d, sin_f(phase_m[15:4]));
            phase_m = phase_m + 16'h00FF;
        end

        // Enable drops during SETUP
        freq_word = 8'h10;
        n = 0;
        while (dac_cs && n < 250) begin @(negedge clk); n++; end
        chk("drop: write started", dac_cs, 0);
        chk("drop: addr", rom_addr, phase_m[15:4]);
        enable = 1'b0;
        @(negedge clk); chk("drop T+5 wr", dac_wr, 0); chk("drop T+5 cs", dac_cs, 0);
        @(negedge clk); chk("drop T+6 wr", dac_wr, 0); chk("drop T+6 cs", dac_cs, 0);
        @(negedge clk); chk("drop T+7 wr", dac_wr, 1); chk("drop T+7 cs", dac_cs, 0);
        @(negedge clk); chk("drop T+8 cs", dac_cs, 1); chk("drop T+8 busy", busy, 0);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!dac_cs) n++;
        end
        chk("drop: no further writes", n, 0);
        enable = 1'b1;
        wait_write(1'b0, 250, d, ab, a, wl, cl, ok);
        chk("reenable form", ok, 1);
        chk("reenable addr", a, 12'h000);
        chk("reenable data", d, 8'h30);

        // Reset asserted during STROBE
        n = 0;
        while (dac_cs && n < 250) begin @(negedge clk); n++; end
        chk("rst: write started", dac_cs, 0);
        chk("rst: addr before reset", rom_addr, 12'h001);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst: dac_cs", dac_cs, 1);
        chk("rst: dac_wr", dac_wr, 1);
        chk("rst: dac_data", dac_data, 0);
        chk("rst: busy", busy, 0);
        rst = 1'b0;
        n = 0;
        while (dac_cs && n < 300) begin @(negedge clk); n++; end
        chk("rst: first write latency", n, 103);
        wait_write(1'b0, 250, d, ab, a, wl, cl, ok);
        chk("rst: first write form", ok, 1);
        chk("rst: first write addr", a, 12'h000);
        chk("rst: first write data", d, 8'h30);
        chk("rst: overrun clear", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dac_wave_sequencer.md
# dac_wave_sequencer

Sequences one DAC sample per tick for the waveform generator. It steps a phase accumulator, presents the 12-bit address to the shared square/sine/triangle sample ROMs, and selects and amplitude-scales the returned byte. It then performs the DAC chip-select/write strobe handshake. It sits between the UART frequency register and switch inputs on one side and the ROMs and DAC pins on the other, and replaces free-running ROM addressing with a controlled, overrun-checked write sequence.

## Interface
- SAMPLE_DIV, 100: clk cycles per sample tick; must be ≥ 8+WR_LOW.
- WR_LOW, 2: cycles dac_wr is held low (≥1).
- PHASE_W, 16: phase accumulator width (≥12).
- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- enable  in  1  run sequencing; low clears phase and tick divider.
- freq_word  in  8  phase increment (UART-received frequency byte).
- wave_sel  in  2  0 square, 1 sine, 2 triangle, 3 = zero output.
- amp  in  4  amplitude 0..15.
- ch_sel  in  1  DAC channel, driven to dac_ab.
- rom_addr  out  12  shared ROM address.
- rom_sq, rom_sin, rom_tri  in  8 each  ROM data; 1-cycle read latency.
- dac_cs  out  1  active-low chip select.
- dac_wr  out  1  active-low write strobe.
- dac_ab  out  1  channel select.
- dac_data  out  8  sample to DAC.
- busy  out  1  sequence in progress (state ≠ IDLE).
- overrun  out  1  sticky; a tick arrived while busy. Cleared only by rst.

## Operation
- Tick divider counts 0..SAMPLE_DIV-1 while enable is high. tick = 1 for one cycle at count SAMPLE_DIV-1.
- FSM states: IDLE → ADDR → FETCH → SCALE → SETUP → STROBE (WR_LOW cycles) → HOLD → IDLE.
- IDLE: on tick && enable, latch wave_sel, amp, ch_sel and freq_word, then go to ADDR. Any other tick in IDLE is ignored.
- ADDR: rom_addr ← phase[PHASE_W-1 -: 12]; phase ← phase + freq_word (zero-extended, modulo 2^PHASE_W, wraps silently).
- FETCH: ROM data becomes valid; select it by the latched wave_sel (sel 3 → 0x00).
- SCALE: the scaled result is registered.
  - amp = 15 → data unchanged.
  - amp = 0 → 0.
  - Otherwise → (data × amp) >> 4, using a 12-bit product truncated to 8 bits.
- SETUP: dac_data ← scaled, dac_ab ← latched ch_sel, dac_cs ← 0.
- STROBE: dac_wr ← 0 for WR_LOW cycles, dac_cs stays 0.
- HOLD: dac_wr ← 1, dac_cs stays 0. On exit, dac_cs ← 1.
- dac_data and dac_ab hold their value until the next SETUP.
- A tick while state ≠ IDLE sets overrun. That tick is dropped; phase does not advance for it.
- If enable drops mid-sequence, the current sequence completes. Phase and divider clear, and no new sequence starts.
- Input changes during a sequence have no effect until the next IDLE latch.
- freq_word = 0: the address stays constant and writes continue.

## Timing
- Reset values:
  - state IDLE; phase, divider and rom_addr 0.
  - dac_cs = 1, dac_wr = 1, dac_ab = 0, dac_data = 0x00.
  - busy = 0, overrun = 0.
- Cycle numbering, with tick sampled in IDLE at cycle T:
  - rom_addr is valid from T+1.
  - dac_cs falls at T+4, with dac_data valid at T+4.
  - dac_wr is low over T+5..T+4+WR_LOW.
  - dac_wr rises at T+5+WR_LOW.
  - dac_cs rises at T+6+WR_LOW.
  - The FSM is back in IDLE at T+6+WR_LOW.
- dac_data is stable for 1 cycle before the dac_wr fall and for ≥1 cycle after the dac_wr rise.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package wave_pkg holds:
  - the FSM state enum;
  - WAVE_SQ = 0, WAVE_SIN = 1, WAVE_TRI = 2, WAVE_OFF = 3;
  - ROM_AW = 12 and DAC_W = 8.
- One sub-module, sample_tick_gen: the SAMPLE_DIV divider, with enable and synchronous clear.
- FSM, phase accumulator, mux and scaler stay in the top of this block.

## Test plan
- Default parameters, freq_word = 0x10, wave_sel = 1, amp = 15, enable high → rom_addr steps 0,1,2,… every 100 cycles; dac_data equals rom_sin one sequence later; dac_wr low exactly 2 cycles per sample.
- amp = 8 with ROM data 0xFF → dac_data 0x7F. amp = 0 → 0x00. wave_sel = 3 → 0x00 with the handshake still toggling.
- freq_word = 0xFF, PHASE_W = 16, run 300 samples → phase wraps past 0xFFFF with no glitch; addresses follow the modulo sequence.
- SAMPLE_DIV forced to 5 (below the sequence length) → overrun sets on the first in-sequence tick and stays 1; every completed write remains well-formed.
- Assert rst during STROBE → next cycle dac_cs = 1, dac_wr = 1, dac_data = 0, busy = 0; after release, the first write occurs at the first tick.
- Drop enable during SETUP → the sequence finishes with dac_cs high at T+6+WR_LOW, no further writes, phase reads 0; on re-enable, rom_addr restarts at 0.
